dfi_init_seq: RTL

- DFI-side initiator that performs DDR3 power-up initialization on the DFI command bus feeding phy_top. It is the controller-end counterpart of the PHY's DFI responder.
- Sequence:
  - Handshake the PHY via dfi_init_start / dfi_init_complete.
  - Run the JEDEC reset/CKE timing.
  - Issue MR2, MR3, MR1, MR0, then ZQCL.
  - Assert init_done.
- Sits between the memory-controller core and phy_top. After init_done, the command mux hands the DFI bus to the scheduler.

---
 rtl/dfi_init_pkg.sv | 47 ++++
 rtl/dfi_init_if.sv | 52 +++++
 rtl/dfi_init_timer.sv | 27 ++
 rtl/dfi_init_seq.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/dfi_init_pkg.sv
// Shared types and constants for the DFI power-up init sequencer.
// Command encodings are {cs_n, ras_n, cas_n, we_n}.
package dfi_init_pkg;

  typedef enum logic [3:0] {
    PHY_INIT,
    RESET_HOLD,
    CKE_WAIT,
    XPR_WAIT,
    MRS,
    MRS_WAIT,
    ZQCL,
    ZQ_WAIT,
    DONE
  } state_t;

  localparam logic [3:0] CMD_DES  = 4'b1111;
  localparam logic [3:0] CMD_MRS  = 4'b0000;
  localparam logic [3:0] CMD_ZQCL = 4'b0110;

  localparam logic [2:0] MR0_BANK = 3'd0;
  localparam logic [2:0] MR1_BANK = 3'd1;
  localparam logic [2:0] MR2_BANK = 3'd2;
  localparam logic [2:0] MR3_BANK = 3'd3;

  // MRS issue order is MR2, MR3, MR1, MR0
  function automatic logic [2:0] mr_bank(
    input logic [1:0] ptr
  );
    logic [2:0] b;
    unique case (ptr)
      2'd0: b = MR2_BANK;
      2'd1: b = MR3_BANK;
      2'd2: b = MR1_BANK;
      default: b = MR0_BANK;
    endcase
    return b;
  endfunction

  function automatic int max2(
    input int a,
    input int b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dfi_init_if.sv
// DFI command/init bundle between the init sequencer and phy_top.
// master drives the command bus, slave is the PHY side.
interface dfi_init_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int BANK_WIDTH = 3,
  parameter int CS_WIDTH   = 2
);

  logic                  dfi_init_complete;
  logic                  dfi_init_start;
  logic                  dfi_reset_n;
  logic [CS_WIDTH-1:0]   dfi_cke;
  logic [CS_WIDTH-1:0]   dfi_odt;
  logic [CS_WIDTH-1:0]   dfi_cs_n;
  logic                  dfi_ras_n;
  logic                  dfi_cas_n;
  logic                  dfi_we_n;
  logic [BANK_WIDTH-1:0] dfi_bank;
  logic [ADDR_WIDTH-1:0] dfi_address;
  logic                  init_done;

  modport master (
    input  dfi_init_complete,
    output dfi_init_start,
    output dfi_reset_n,
    output dfi_cke,
    output dfi_odt,
    output dfi_cs_n,
    output dfi_ras_n,
    output dfi_cas_n,
    output dfi_we_n,
    output dfi_bank,
    output dfi_address,
    output init_done
  );

  modport slave (
    output dfi_init_complete,
    input  dfi_init_start,
    input  dfi_reset_n,
    input  dfi_cke,
    input  dfi_odt,
    input  dfi_cs_n,
    input  dfi_ras_n,
    input  dfi_cas_n,
    input  dfi_we_n,
    input  dfi_bank,
    input  dfi_address,
    input  init_done
  );

endinterface

// File: rtl/dfi_init_timer.sv
// Loadable down-counter that sticks at zero.
// zero is high whenever the count has run out.
module dfi_init_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/dfi_init_seq.sv
// DDR3 power-up initiator on the DFI bus: PHY handshake, RESET#/CKE
// timing, MR2/MR3/MR1/MR0 then ZQCL, then sticky init_done.
module dfi_init_seq
  import dfi_init_pkg::*;
#(
  parameter int          ADDR_WIDTH = 16,
  parameter int          BANK_WIDTH = 3,
  parameter int          CS_WIDTH   = 2,
  parameter int          T_RESET    = 160000,
  parameter int          T_CKE      = 400000,
  parameter int          T_XPR      = 216,
  parameter int          T_MRD      = 4,
  parameter int          T_MOD      = 12,
  parameter int          T_ZQINIT   = 512,
  parameter logic [15:0] MR0_VAL    = 16'h1D70,
  parameter logic [15:0] MR1_VAL    = 16'h0044,
  parameter logic [15:0] MR2_VAL    = 16'h0208,
  parameter logic [15:0] MR3_VAL    = 16'h0000
) (
  input  logic      dfi_clk,
  input  logic      dfi_arst,
  dfi_init_if.master bus
);

  localparam int T_MAX = max2(max2(max2(T_RESET, T_CKE),
                                   max2(T_XPR, T_MRD)),
                              max2(T_MOD, T_ZQINIT));
  localparam int TW = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam logic [ADDR_WIDTH-1:0] ZQ_ADDR =
    ADDR_WIDTH'(1) << 10;

  state_t                state;
  logic [1:0]            mr_ptr;
  logic [3:0]            cmd;
  logic [BANK_WIDTH-1:0] bank;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  init_start;
  logic                  reset_n;
  logic                  cke;
  logic                  done;
  logic                  load;
  logic [TW-1:0]         load_val;
  logic                  zero;
  logic [ADDR_WIDTH-1:0] mr_val;

  dfi_init_timer #(.W(TW)) u_timer (
    .clk      (dfi_clk),
    .rst      (dfi_arst),
    .load     (load),
    .load_val (load_val),
    .zero     (zero)
  );

  always_comb begin
    mr_val = '0;
    unique case (mr_ptr)
      2'd0: mr_val = ADDR_WIDTH'(MR2_VAL);
      2'd1: mr_val = ADDR_WIDTH'(MR3_VAL);
      2'd2: mr_val = ADDR_WIDTH'(MR1_VAL);
      default: mr_val = ADDR_WIDTH'(MR0_VAL);
    endcase
  end

  // Waits that end in a command state load N-2: one cycle is spent
  // in the command state itself before the command hits the bus.
  always_comb begin
    load     = 1'b0;
    load_val = '0;
    unique case (state)
      PHY_INIT: begin
        load     = bus.dfi_init_complete;
        load_val = TW'(T_RESET - 1);
      end
      RESET_HOLD: begin
        load     = zero;
        load_val = TW'(T_CKE - 1);
      end
      CKE_WAIT: begin
        load     = zero;
        load_val = TW'(T_XPR - 2);
      end
      MRS: begin
        load     = 1'b1;
        load_val = (mr_ptr == 2'd3) ? TW'(T_MOD - 2)
                                    : TW'(T_MRD - 2);
      end
      ZQCL: begin
        load     = 1'b1;
        load_val = TW'(T_ZQINIT - 1);
      end
      default: begin
        load     = 1'b0;
        load_val = '0;
      end
    endcase
  end

  always_ff @(posedge dfi_clk or posedge dfi_arst) begin
    if (dfi_arst) begin
      state      <= PHY_INIT;
      mr_ptr     <= '0;
      cmd        <= CMD_DES;
      bank       <= '0;
      addr       <= '0;
      init_start <= 1'b0;
      reset_n    <= 1'b0;
      cke        <= 1'b0;
      done       <= 1'b0;
    end else begin
      cmd  <= CMD_DES;
      bank <= '0;
      addr <= '0;
      unique case (state)
        PHY_INIT: begin
          if (bus.dfi_init_complete) begin
            init_start <= 1'b0;
            state      <= RESET_HOLD;
          end else begin
            init_start <= 1'b1;
          end
        end
        RESET_HOLD: begin
          if (zero) begin
            reset_n <= 1'b1;
            state   <= CKE_WAIT;
          end
        end
        CKE_WAIT: begin
          if (zero) begin
            cke   <= 1'b1;
            state <= XPR_WAIT;
          end
        end
        XPR_WAIT: begin
          if (zero) state <= MRS;
        end
        MRS: begin
          cmd    <= CMD_MRS;
          bank   <= BANK_WIDTH'(mr_bank(mr_ptr));
          addr   <= mr_val;
          mr_ptr <= mr_ptr + 2'd1;
          state  <= MRS_WAIT;
        end
        // pointer wraps to 0 once MR0 has gone out
        MRS_WAIT: begin
          if (zero) state <= (mr_ptr == 2'd0) ? ZQCL : MRS;
        end
        ZQCL: begin
          cmd   <= CMD_ZQCL;
          addr  <= ZQ_ADDR;
          state <= ZQ_WAIT;
        end
        ZQ_WAIT: begin
          if (zero) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= DONE;
      endcase
    end
  end

  assign bus.dfi_init_start = init_start;
  assign bus.dfi_reset_n    = reset_n;
  assign bus.dfi_cke        = {CS_WIDTH{cke}};
  assign bus.dfi_odt        = '0;
  assign bus.dfi_cs_n       = {CS_WIDTH{cmd[3]}};
  assign bus.dfi_ras_n      = cmd[2];
  assign bus.dfi_cas_n      = cmd[1];
  assign bus.dfi_we_n       = cmd[0];
  assign bus.dfi_bank       = bank;
  assign bus.dfi_address    = addr;
  assign bus.init_done      = done;

endmodule
